// File: rtl/periph_pkg.sv
// Register map offsets and TCON bit positions shared by the timer bank.
package periph_pkg;

  // Per-channel register offsets within a channel's 16-byte slot.
  localparam logic [8:0] OFF_TH    = 9'h000;
  localparam logic [8:0] OFF_TL    = 9'h004;
  localparam logic [8:0] OFF_TCON  = 9'h008;
  localparam logic [8:0] OFF_STAT  = 9'h00C;
  localparam logic [8:0] CH_STRIDE = 9'h010;

  // Global registers in the upper half of the window.
  localparam logic [8:0] OFF_LED    = 9'h100;
  localparam logic [8:0] OFF_SW     = 9'h104;
  localparam logic [8:0] OFF_DIGI   = 9'h108;
  localparam logic [8:0] OFF_IRQSUM = 9'h10C;
  localparam logic [8:0] OFF_PRESC  = 9'h110;

  // TCON bit indices.
  localparam int unsigned TCON_EN      = 0;
  localparam int unsigned TCON_IRQ_EN  = 1;
  localparam int unsigned TCON_ONESHOT = 2;

endpackage

// File: rtl/timer_channel.sv
// One reload timer: TH/TL/TCON/STAT with bus-write override and sticky overflow status.
module timer_channel
  import periph_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             we_th_i,
  input  logic             we_tl_i,
  input  logic             we_tcon_i,
  input  logic             we_stat_i,
  input  logic [31:0]      wdata_i,
  output logic [CNT_W-1:0] th_o,
  output logic [CNT_W-1:0] tl_o,
  output logic [2:0]       tcon_o,
  output logic             stat_o
);

  logic [CNT_W-1:0] th_q, th_d, tl_q, tl_d;
  logic [2:0]       tcon_q, tcon_d;
  logic             stat_q, stat_d;
  logic             run, ovf;
  logic             unused_wdata;

  assign unused_wdata = ^wdata_i;
  assign run = tcon_q[TCON_EN] & tick_i;
  assign ovf = run & (&tl_q);

  // Timer update first, then bus writes override; overflow set beats W1C clear.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    stat_d = stat_q;
    if (run) tl_d = ovf ? th_q : tl_q + CNT_W'(1);
    if (ovf && tcon_q[TCON_ONESHOT]) tcon_d[TCON_EN] = 1'b0;
    if (we_stat_i && wdata_i[0]) stat_d = 1'b0;
    if (ovf) stat_d = 1'b1;
    if (we_th_i) th_d = wdata_i[CNT_W-1:0];
    if (we_tl_i) tl_d = wdata_i[CNT_W-1:0];
    if (we_tcon_i) tcon_d = wdata_i[2:0];
  end

  // Channel state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
      stat_q <= 1'b0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      stat_q <= stat_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign tcon_o = tcon_q;
  assign stat_o = stat_q;

endmodule

// File: rtl/timer_bank_periph.sv
// Memory-mapped timer bank: address decode, shared prescaler, LED/DIGI regs, read mux, IRQ OR.
module timer_bank_periph
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE   = 32'h4000_0000,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned PRE_W  = 16,
  parameter int unsigned LED_W  = 8,
  parameter int unsigned SW_W   = 8,
  parameter int unsigned DIGI_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rd_i,
  input  logic              wr_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  input  logic [SW_W-1:0]   switch_i,
  output logic [LED_W-1:0]  led_o,
  output logic [DIGI_W-1:0] digi_o,
  output logic              irqout_o
);

  logic             in_win, ch_area, glob_area;
  logic [8:0]       off;
  logic [3:0]       ch_sel;
  logic [1:0]       reg_sel;
  logic [6:0]       gsel;
  logic             unused_addr;

  // Window is 512 bytes; channel k occupies off[7:4]==k in the lower half.
  assign in_win      = (addr_i[31:9] == BASE[31:9]);
  assign off         = addr_i[8:0];
  assign ch_area     = in_win & ~off[8];
  assign glob_area   = in_win & off[8];
  assign ch_sel      = off[7:4];
  assign reg_sel     = off[3:2];
  assign gsel        = off[8:2];
  assign unused_addr = ^off[1:0];

  logic [CNT_W-1:0]  th   [NUM_CH];
  logic [CNT_W-1:0]  tl   [NUM_CH];
  logic [2:0]        tcon [NUM_CH];
  logic [NUM_CH-1:0] stat, pend;

  logic [PRE_W-1:0]  pcnt_q, pcnt_d, presc_q;
  logic [LED_W-1:0]  led_q;
  logic [DIGI_W-1:0] digi_q;
  logic              tick, we_led, we_digi, we_presc;

  assign we_led   = wr_i & glob_area & (gsel == OFF_LED[8:2]);
  assign we_digi  = wr_i & glob_area & (gsel == OFF_DIGI[8:2]);
  assign we_presc = wr_i & glob_area & (gsel == OFF_PRESC[8:2]);
  assign tick     = (pcnt_q == presc_q);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic hit;
    assign hit = ch_area & (ch_sel == 4'(k));
    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .tick_i   (tick),
      .we_th_i  (wr_i & hit & (reg_sel == OFF_TH[3:2])),
      .we_tl_i  (wr_i & hit & (reg_sel == OFF_TL[3:2])),
      .we_tcon_i(wr_i & hit & (reg_sel == OFF_TCON[3:2])),
      .we_stat_i(wr_i & hit & (reg_sel == OFF_STAT[3:2])),
      .wdata_i  (wdata_i),
      .th_o     (th[k]),
      .tl_o     (tl[k]),
      .tcon_o   (tcon[k]),
      .stat_o   (stat[k])
    );
    assign pend[k] = stat[k] & tcon[k][TCON_IRQ_EN];
  end

  assign irqout_o = |pend;

  // Prescaler counts 0..PRESC; a PRESC write restarts it.
  always_comb begin
    pcnt_d = pcnt_q + PRE_W'(1);
    if (tick) pcnt_d = '0;
    if (we_presc) pcnt_d = '0;
  end

  // Global registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q  <= '0;
      presc_q <= '0;
      led_q   <= '0;
      digi_q  <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      if (we_presc) presc_q <= wdata_i[PRE_W-1:0];
      if (we_led) led_q <= wdata_i[LED_W-1:0];
      if (we_digi) digi_q <= wdata_i[DIGI_W-1:0];
    end
  end

  // Read mux: zero-extended register, 0 when idle or unmapped.
  always_comb begin
    rdata_o = '0;
    if (rd_i && ch_area) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_sel == 4'(k)) begin
          case (reg_sel)
            OFF_TH[3:2]:   rdata_o[CNT_W-1:0] = th[k];
            OFF_TL[3:2]:   rdata_o[CNT_W-1:0] = tl[k];
            OFF_TCON[3:2]: rdata_o[2:0] = tcon[k];
            default:       rdata_o[0] = stat[k];
          endcase
        end
      end
    end else if (rd_i && glob_area) begin
      case (gsel)
        OFF_LED[8:2]:    rdata_o[LED_W-1:0] = led_q;
        OFF_SW[8:2]:     rdata_o[SW_W-1:0] = switch_i;
        OFF_DIGI[8:2]:   rdata_o[DIGI_W-1:0] = digi_q;
        OFF_IRQSUM[8:2]: rdata_o[NUM_CH-1:0] = pend;
        OFF_PRESC[8:2]:  rdata_o[PRE_W-1:0] = presc_q;
        default:         rdata_o = '0;
      endcase
    end
  end

  assign led_o  = led_q;
  assign digi_o = digi_q;

endmodule

// File: tb/tb_timer_bank_periph.sv
// Scoreboard bench: driver pushes model-predicted outputs per cycle, monitor pops and compares.
module tb_timer_bank_periph;

  logic        clk, rst_n, rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  sw, led;
  logic [11:0] digi;
  logic        irq;

  timer_bank_periph dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .rd_i    (rd),
    .wr_i    (wr),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .switch_i(sw),
    .led_o   (led),
    .digi_o  (digi),
    .irqout_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] B = 32'h4000_0000;
  localparam int TH = 0, TL = 1, TCON = 2, STAT = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        irq;
    logic [7:0]  led;
    logic [11:0] digi;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int sw_fix = -1;

  // Reference model: registers as plain arrays, updated by the written rules.
  logic [31:0] m_th[2], m_tl[2];
  logic [2:0]  m_tcon[2];
  logic        m_stat[2];
  logic [15:0] m_presc, m_pcnt;
  logic [7:0]  m_led;
  logic [11:0] m_digi;

  function automatic logic [31:0] ra(input int ch, input int r);
    return B + 32'(ch * 16 + r * 4);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      m_th[i] = 0; m_tl[i] = 0; m_tcon[i] = 0; m_stat[i] = 0;
    end
    m_presc = 0; m_pcnt = 0; m_led = 0; m_digi = 0;
  endfunction

  function automatic logic [1:0] m_pend();
    logic [1:0] p;
    for (int i = 0; i < 2; i++) p[i] = m_stat[i] & m_tcon[i][1];
    return p;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [7:0] s);
    int off, ch;
    if (a < B || a > B + 32'h1FF) return 0;
    off = int'(a - B) & 'h1FC;
    if (off < 'h100) begin
      ch = off / 16;
      if (ch >= 2) return 0;
      case ((off % 16) / 4)
        0: return m_th[ch];
        1: return m_tl[ch];
        2: return {29'b0, m_tcon[ch]};
        default: return {31'b0, m_stat[ch]};
      endcase
    end
    case (off)
      'h100: return {24'b0, m_led};
      'h104: return {24'b0, s};
      'h108: return {20'b0, m_digi};
      'h10C: return {30'b0, m_pend()};
      'h110: return {16'b0, m_presc};
      default: return 0;
    endcase
  endfunction

  function automatic void m_step(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic        tick;
    logic [31:0] ntl[2];
    logic [2:0]  ntc[2];
    logic        nst[2], ovf[2];
    int          off, ch;
    tick = (m_pcnt == m_presc);
    for (int i = 0; i < 2; i++) begin
      ovf[i] = m_tcon[i][0] && tick && (m_tl[i] == 32'hFFFF_FFFF);
      ntl[i] = m_tl[i];
      if (m_tcon[i][0] && tick) ntl[i] = ovf[i] ? m_th[i] : m_tl[i] + 1;
      ntc[i] = (ovf[i] && m_tcon[i][2]) ? (m_tcon[i] & 3'b110) : m_tcon[i];
      nst[i] = ovf[i] ? 1'b1 : m_stat[i];
    end
    m_pcnt = tick ? 16'd0 : m_pcnt + 16'd1;
    if (w && a >= B && a <= B + 32'h1FF) begin
      off = int'(a - B) & 'h1FC;
      if (off < 'h100) begin
        ch = off / 16;
        if (ch < 2) begin
          case ((off % 16) / 4)
            0: m_th[ch] = d;
            1: ntl[ch] = d;
            2: ntc[ch] = d[2:0];
            default: if (d[0] && !ovf[ch]) nst[ch] = 1'b0;
          endcase
        end
      end else begin
        case (off)
          'h100: m_led = d[7:0];
          'h108: m_digi = d[11:0];
          'h110: begin m_presc = d[15:0]; m_pcnt = 0; end
          default: ;
        endcase
      end
    end
    for (int i = 0; i < 2; i++) begin
      m_tl[i] = ntl[i]; m_tcon[i] = ntc[i]; m_stat[i] = nst[i];
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive, predict this cycle's outputs, advance model across the next edge.
  task automatic bus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    rd = r; wr = w; addr = a; wdata = d;
    sw = (sw_fix >= 0) ? 8'(sw_fix) : 8'($urandom);
    e.rdata = r ? m_read(a, sw) : 32'd0;
    e.irq   = |m_pend();
    e.led   = m_led;
    e.digi  = m_digi;
    q.push_back(e);
    m_step(w, a, d);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    bus(1'b0, 1'b1, a, d);
  endtask

  task automatic rd_reg(input logic [31:0] a);
    bus(1'b1, 1'b0, a, 32'd0);
  endtask

  // Monitor: compare every presented cycle against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rdata", rdata, e.rdata);
      chk("irqout", {31'b0, irq}, {31'b0, e.irq});
      chk("led", {24'b0, led}, {24'b0, e.led});
      chk("digi", {20'b0, digi}, {20'b0, e.digi});
    end
  end

  initial begin
    int op, ch, r;
    logic [31:0] a, d;
    rst_n = 1'b0; rd = 0; wr = 0; addr = 0; wdata = 0; sw = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset state.
    for (int i = 0; i < 2; i++) for (int j = 0; j < 4; j++) rd_reg(ra(i, j));
    rd_reg(B + 32'h110);

    // Auto-reload with irq, tick every clock.
    wr_reg(B + 32'h110, 0);
    wr_reg(ra(0, TH), 32'hFFFF_FFFC);
    wr_reg(ra(0, TL), 32'hFFFF_FFFC);
    wr_reg(ra(0, TCON), 3);
    for (int i = 0; i < 6; i++) rd_reg(ra(0, (i % 2) ? STAT : TL));

    // Prescaled counting and a PRESC rewrite mid-run.
    wr_reg(ra(1, TL), 0);
    wr_reg(B + 32'h110, 3);
    wr_reg(ra(1, TCON), 1);
    for (int i = 0; i < 40; i++) rd_reg(ra(1, TL));
    wr_reg(B + 32'h110, 3);
    for (int i = 0; i < 8; i++) rd_reg(ra(1, TL));

    // Quiesce ch0, then one-shot on ch1.
    wr_reg(ra(0, TCON), 0);
    wr_reg(ra(0, STAT), 1);
    wr_reg(ra(1, TCON), 0);
    wr_reg(B + 32'h110, 0);
    wr_reg(ra(1, TH), 32'h0000_1234);
    wr_reg(ra(1, TL), 32'hFFFF_FFFF);
    wr_reg(ra(1, TCON), 7);
    for (int i = 0; i < 3; i++) rd_reg(ra(1, TCON));
    rd_reg(ra(1, TL));
    rd_reg(B + 32'h10C);
    wr_reg(ra(1, STAT), 1);
    rd_reg(B + 32'h10C);
    rd_reg(ra(1, STAT));

    // W1C coincident with overflow: set wins.
    wr_reg(ra(0, TCON), 1);
    wr_reg(ra(0, TL), 32'hFFFF_FFFD);
    bus(0, 0, 0, 0);
    bus(0, 0, 0, 0);
    wr_reg(ra(0, STAT), 1);
    rd_reg(ra(0, STAT));
    // TL write coincident with overflow: write wins, STAT still set.
    wr_reg(ra(0, STAT), 1);
    wr_reg(ra(0, TL), 32'hFFFF_FFFE);
    bus(0, 0, 0, 0);
    wr_reg(ra(0, TL), 32'h0000_0055);
    rd_reg(ra(0, TL));
    rd_reg(ra(0, STAT));

    // Globals and unmapped space.
    sw_fix = 'hA5;
    rd_reg(B + 32'h104);
    sw_fix = -1;
    rd_reg(B + 32'h30);
    wr_reg(B + 32'h30, 32'hFFFF_FFFF);
    rd_reg(B + 32'h30);
    wr_reg(B + 32'h100, 32'h1FF);
    wr_reg(B + 32'h108, 32'hFFFF);
    rd_reg(B + 32'h100);
    rd_reg(B + 32'h108);
    rd_reg(B + 32'h200);

    // Async reset with irqout high mid-count.
    wr_reg(ra(0, TL), 32'hFFFF_FFFF);
    wr_reg(ra(0, TCON), 3);
    bus(0, 0, 0, 0);
    rd_reg(ra(0, TL));
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst irqout", {31'b0, irq}, 32'd0);
    chk("rst led", {24'b0, led}, 32'd0);
    chk("rst digi", {20'b0, digi}, 32'd0);
    chk("rst rdata", rdata, 32'd0);
    m_reset();
    m_step(1'b0, 32'd0, 32'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) rd_reg(ra(i % 2, (i < 2) ? TL : TCON));
    rd_reg(B + 32'h10C);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      op = $urandom_range(0, 11);
      d = $urandom;
      if (op <= 7) begin
        ch = $urandom_range(0, 2);
        r = $urandom_range(0, 3);
        a = ra(ch, r);
        if (r == TL && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        if (r == TCON) d = 32'($urandom_range(0, 7));
      end else if (op == 8) a = B + 32'h100;
      else if (op == 9) a = B + 32'h108;
      else if (op == 10) begin
        a = B + 32'h110;
        d = 32'($urandom_range(0, 3));
      end else begin
        case ($urandom_range(0, 4))
          0: a = B + 32'h104;
          1: a = B + 32'h10C;
          2: a = B + 32'h200;
          3: a = B - 32'd4;
          default: a = B + 32'h114;
        endcase
      end
      case ($urandom_range(0, 3))
        0: bus(1'b0, 1'b1, a, d);
        1: bus(1'b1, 1'b1, a, d);
        2: bus(1'b0, 1'b0, a, d);
        default: bus(1'b1, 1'b0, a, d);
      endcase
    end
    bus(0, 0, 0, 0);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
